// File: rtl/action_engine_pipe.sv
// Per-container action engine: a 2-stage ALU pipeline feeding a credit-guarded output FIFO.
// Define ACTION_ENGINE_STATS_EN to add the stat_pkt_cnt / stat_stall_cnt counter ports.
module action_engine_pipe #(
    parameter int unsigned STAGE_ID  = 0,
    parameter int unsigned NUM_6B    = 8,
    parameter int unsigned NUM_4B    = 8,
    parameter int unsigned NUM_2B    = 8,
    parameter int unsigned META_LEN  = 256,
    parameter int unsigned ACT_LEN   = 25,
    parameter int unsigned OUT_DEPTH = 4,
    localparam int unsigned PHV_LEN  = 48*NUM_6B + 32*NUM_4B + 16*NUM_2B + META_LEN,
    localparam int unsigned NSLOT    = NUM_6B + NUM_4B + NUM_2B + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PHV_LEN-1:0]         phv_in,
    input  logic                       phv_valid_in,
    input  logic [ACT_LEN*NSLOT-1:0]   action_in,
    input  logic                       action_valid_in,
    output logic                       ready_out,
    output logic [PHV_LEN-1:0]         phv_out,
    output logic                       phv_valid_out,
    input  logic                       ready_in
`ifdef ACTION_ENGINE_STATS_EN
    ,
    output logic [31:0]                stat_pkt_cnt,
    output logic [31:0]                stat_stall_cnt
`endif
);

    localparam int unsigned O2 = META_LEN;
    localparam int unsigned O4 = O2 + 16*NUM_2B;
    localparam int unsigned O6 = O4 + 32*NUM_4B;
    localparam int unsigned PW = $clog2(OUT_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;

    function automatic logic [47:0] alu(input logic [3:0]  op,
                                        input logic [47:0] cur,
                                        input logic [15:0] imm,
                                        input logic [47:0] cpy,
                                        input logic        cpy_ok);
        case (op)
            4'd1:    alu = cur + {32'd0, imm};
            4'd2:    alu = cur - {32'd0, imm};
            4'd3:    alu = {32'd0, imm};
            4'd4:    alu = cpy_ok ? cpy : cur;
            default: alu = cur;
        endcase
    endfunction

    logic                     r1_vld;
    logic [PHV_LEN-1:0]       r1_phv;
    logic [ACT_LEN*NSLOT-1:0] r1_act;
    logic                     r2_vld;
    logic [PHV_LEN-1:0]       r2_phv;
    logic [PHV_LEN-1:0]       r_mem [OUT_DEPTH];
    logic [PW-1:0]            r_wr;
    logic [PW-1:0]            r_rd;
    logic [CW-1:0]            r_cnt;

    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic [OW-1:0]            w_occ;
    logic [PHV_LEN-1:0]       w_phv_alu;
    logic [ACT_LEN-1:0]       w_sub;
    logic [47:0]              w_cpy;
    logic                     w_cpy_ok;
    logic [47:0]              w_res;

    // Occupancy counts entries still in the pipe, so the FIFO always has room for them.
    assign w_occ     = OW'(r_cnt) + OW'(r1_vld) + OW'(r2_vld);
    assign ready_out = (w_occ < OW'(OUT_DEPTH));
    assign w_accept  = phv_valid_in & action_valid_in & ready_out;
    assign w_push    = r2_vld;
    assign w_pop     = phv_valid_out & ready_in;

    assign phv_valid_out = (r_cnt != '0);
    assign phv_out       = phv_valid_out ? r_mem[r_rd] : '0;

    // Every operand (including COPY sources) comes from the unmodified stage-1 PHV.
    always_comb begin
        w_phv_alu = r1_phv;
        w_sub     = '0;
        w_cpy     = '0;
        w_cpy_ok  = 1'b0;
        w_res     = '0;
        for (int unsigned i = 0; i < NUM_2B; i++) begin
            w_sub    = r1_act[ACT_LEN*(1+i) +: ACT_LEN];
            w_cpy    = '0;
            w_cpy_ok = 1'b0;
            for (int unsigned j = 0; j < NUM_2B; j++) begin
                if (32'(w_sub[20:16]) == j) begin
                    w_cpy    = {32'd0, r1_phv[O2+16*j +: 16]};
                    w_cpy_ok = 1'b1;
                end
            end
            w_res = alu(w_sub[24:21], {32'd0, r1_phv[O2+16*i +: 16]}, w_sub[15:0], w_cpy, w_cpy_ok);
            w_phv_alu[O2+16*i +: 16] = w_res[15:0];
        end
        for (int unsigned i = 0; i < NUM_4B; i++) begin
            w_sub    = r1_act[ACT_LEN*(1+NUM_2B+i) +: ACT_LEN];
            w_cpy    = '0;
            w_cpy_ok = 1'b0;
            for (int unsigned j = 0; j < NUM_4B; j++) begin
                if (32'(w_sub[20:16]) == j) begin
                    w_cpy    = {16'd0, r1_phv[O4+32*j +: 32]};
                    w_cpy_ok = 1'b1;
                end
            end
            w_res = alu(w_sub[24:21], {16'd0, r1_phv[O4+32*i +: 32]}, w_sub[15:0], w_cpy, w_cpy_ok);
            w_phv_alu[O4+32*i +: 32] = w_res[31:0];
        end
        for (int unsigned i = 0; i < NUM_6B; i++) begin
            w_sub    = r1_act[ACT_LEN*(1+NUM_2B+NUM_4B+i) +: ACT_LEN];
            w_cpy    = '0;
            w_cpy_ok = 1'b0;
            for (int unsigned j = 0; j < NUM_6B; j++) begin
                if (32'(w_sub[20:16]) == j) begin
                    w_cpy    = r1_phv[O6+48*j +: 48];
                    w_cpy_ok = 1'b1;
                end
            end
            w_res = alu(w_sub[24:21], r1_phv[O6+48*i +: 48], w_sub[15:0], w_cpy, w_cpy_ok);
            w_phv_alu[O6+48*i +: 48] = w_res;
        end
        w_sub = r1_act[0 +: ACT_LEN];
        if (w_sub[24:21] == 4'd3) begin
            w_phv_alu[15:0] = w_sub[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_vld <= 1'b0;
            r2_vld <= 1'b0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
        end else begin
            r1_vld <= w_accept;
            r2_vld <= r1_vld;
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r1_phv <= phv_in;
            r1_act <= action_in;
        end
        if (r1_vld) begin
            r2_phv <= w_phv_alu;
        end
        if (w_push) begin
            r_mem[r_wr] <= r2_phv;
        end
    end

`ifdef ACTION_ENGINE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_pkt_cnt   <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
            end
            if (phv_valid_out && !ready_in) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_action_engine_pipe.sv
// Directed bench for action_engine_pipe: opcodes, latency, ordering, backpressure and reset.
module tb_action_engine_pipe;

    localparam int unsigned N6 = 8, N4 = 8, N2 = 8, ML = 256, AL = 25, DEPTH = 4;
    localparam int unsigned PL = 48*N6 + 32*N4 + 16*N2 + ML;
    localparam int unsigned NS = N6 + N4 + N2 + 1;
    localparam int unsigned AW = AL*NS;
    localparam int unsigned O2 = ML, O4 = O2 + 16*N2, O6 = O4 + 32*N4;
    localparam int unsigned S2 = 1, S4 = 1 + N2, S6 = 1 + N2 + N4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PL-1:0] phv_in;
    logic          phv_valid_in;
    logic [AW-1:0] action_in;
    logic          action_valid_in;
    logic          ready_out;
    logic [PL-1:0] phv_out;
    logic          phv_valid_out;
    logic          ready_in;
`ifdef ACTION_ENGINE_STATS_EN
    logic [31:0]   stat_pkt_cnt;
    logic [31:0]   stat_stall_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    action_engine_pipe #(
        .STAGE_ID(0), .NUM_6B(N6), .NUM_4B(N4), .NUM_2B(N2),
        .META_LEN(ML), .ACT_LEN(AL), .OUT_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .action_in(action_in), .action_valid_in(action_valid_in),
        .ready_out(ready_out), .phv_out(phv_out),
        .phv_valid_out(phv_valid_out), .ready_in(ready_in)
`ifdef ACTION_ENGINE_STATS_EN
        , .stat_pkt_cnt(stat_pkt_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [PL-1:0] w6(input logic [PL-1:0] p, input int unsigned i, input logic [47:0] v);
        w6 = p;
        w6[O6+48*i +: 48] = v;
    endfunction

    function automatic logic [PL-1:0] w4(input logic [PL-1:0] p, input int unsigned i, input logic [31:0] v);
        w4 = p;
        w4[O4+32*i +: 32] = v;
    endfunction

    function automatic logic [PL-1:0] w2(input logic [PL-1:0] p, input int unsigned i, input logic [15:0] v);
        w2 = p;
        w2[O2+16*i +: 16] = v;
    endfunction

    function automatic logic [AW-1:0] ap(input logic [AW-1:0] a, input int unsigned slot,
                                         input logic [3:0] op, input logic [4:0] src, input logic [15:0] imm);
        ap = a;
        ap[AL*slot +: AL] = {op, src, imm};
    endfunction

    function automatic logic [PL-1:0] tag(input int unsigned k);
        logic [31:0] t;
        t = 32'hC0DE_0000 | k;
        tag = {32{t}};
    endfunction

    function automatic int first_diff(input logic [PL-1:0] a, input logic [PL-1:0] b);
        first_diff = 0;
        for (int w = PL/64 - 1; w >= 0; w--) begin
            if (a[64*w +: 64] !== b[64*w +: 64]) first_diff = w;
        end
    endfunction

    task automatic chk(input string name, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
        int w;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            w = first_diff(obs, exp);
            $error("FAIL %s: word %0d observed %h required %h", name, w, obs[64*w +: 64], exp[64*w +: 64]);
        end
    endtask

    task automatic chks(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PL-1:0] p, input logic [AW-1:0] a);
        phv_in          = p;
        action_in       = a;
        phv_valid_in    = 1'b1;
        action_valid_in = 1'b1;
        tick();
        phv_valid_in    = 1'b0;
        action_valid_in = 1'b0;
    endtask

    initial begin
        logic [PL-1:0] base, p, exp;
        logic [AW-1:0] a;
        int            acc;
        logic          r;

        rst_n = 1'b0; phv_valid_in = 1'b0; action_valid_in = 1'b0;
        ready_in = 1'b1; phv_in = '0; action_in = '0;
        tick(); tick();
        rst_n = 1'b1;
        chks("rst_valid_out", 32'(phv_valid_out), 32'd0);
        chks("rst_ready_out", 32'(ready_out), 32'd1);
        chk ("rst_phv_out", phv_out, '0);
`ifdef ACTION_ENGINE_STATS_EN
        chks("rst_pkt_cnt", stat_pkt_cnt, 32'd0);
        chks("rst_stall_cnt", stat_stall_cnt, 32'd0);
`endif

        base = '0;
        for (int unsigned i = 0; i < N6; i++) base = w6(base, i, 48'h6B00_0000_0000 + 48'(i));
        for (int unsigned i = 0; i < N4; i++) base = w4(base, i, 32'h4B00_0000 + i);
        for (int unsigned i = 0; i < N2; i++) base = w2(base, i, 16'h2B00 + 16'(i));
        base[ML-1:0] = {8{32'hDEAD_BEEF}};

        // ADD wrap on 6B[0], exact 2-cycle latency
        p   = w6(base, 0, 48'hFFFF_FFFF_FFFF);
        a   = ap('0, S6+0, 4'd1, 5'd0, 16'd1);
        exp = w6(base, 0, 48'd0);
        send(p, a);
        chks("add6_lat1", 32'(phv_valid_out), 32'd0);
        tick();
        chks("add6_lat2", 32'(phv_valid_out), 32'd0);
        tick();
        chks("add6_valid", 32'(phv_valid_out), 32'd1);
        chk ("add6_data", phv_out, exp);
        tick();
        chks("add6_drained", 32'(phv_valid_out), 32'd0);
`ifdef ACTION_ENGINE_STATS_EN
        chks("add6_pkt_cnt", stat_pkt_cnt, 32'd1);
`endif

        // SET/COPY on 2B, wraps, unmodified-source COPY, metadata SET
        p = w2(base, 3, 16'h1234);
        p = w2(p, 0, 16'h0055);
        p = w2(p, 5, 16'hFFFF);
        p = w4(p, 1, 32'hFFFF_FFF0);
        p = w6(p, 2, 48'd5);
        a = ap('0, S2+3, 4'd3, 5'd0, 16'hBEEF);
        a = ap(a, S2+0, 4'd4, 5'd3, 16'h0000);
        a = ap(a, S2+5, 4'd1, 5'd0, 16'h0002);
        a = ap(a, S4+1, 4'd1, 5'd0, 16'h0020);
        a = ap(a, S4+2, 4'd3, 5'd0, 16'h7777);
        a = ap(a, S4+7, 4'd4, 5'd2, 16'h0000);
        a = ap(a, S6+2, 4'd2, 5'd0, 16'h0006);
        a = ap(a, S6+5, 4'd3, 5'd0, 16'hABCD);
        a = ap(a, 0,    4'd3, 5'd0, 16'hCAFE);
        exp = w2(p, 3, 16'hBEEF);
        exp = w2(exp, 0, 16'h1234);
        exp = w2(exp, 5, 16'h0001);
        exp = w4(exp, 1, 32'h0000_0010);
        exp = w4(exp, 2, 32'h0000_7777);
        exp = w4(exp, 7, 32'h4B00_0002);
        exp = w6(exp, 2, 48'hFFFF_FFFF_FFFF);
        exp = w6(exp, 5, 48'h0000_0000_ABCD);
        exp[15:0] = 16'hCAFE;
        send(p, a);
        tick(); tick();
        chks("mix_valid", 32'(phv_valid_out), 32'd1);
        chk ("mix_data", phv_out, exp);
        tick();

        // Invalid ops leave containers untouched; one legal 6B COPY alongside
        a = ap('0, S4+0, 4'd4, 5'd9, 16'h0000);
        a = ap(a, S4+3, 4'd7, 5'd0, 16'hFFFF);
        a = ap(a, S6+1, 4'd4, 5'd8, 16'h0000);
        a = ap(a, S2+6, 4'd15, 5'd0, 16'h0001);
        a = ap(a, S6+4, 4'd4, 5'd7, 16'h0000);
        a = ap(a, 0,    4'd1, 5'd0, 16'h1234);
        exp = w6(base, 4, 48'h6B00_0000_0007);
        send(base, a);
        tick(); tick();
        chks("nop_valid", 32'(phv_valid_out), 32'd1);
        chk ("nop_data", phv_out, exp);
        tick();

        // Mismatched valids accept nothing
        phv_in = tag(99); action_in = '0;
        phv_valid_in = 1'b1; action_valid_in = 1'b0;
        tick(); tick(); tick();
        chks("mismatch_no_out", 32'(phv_valid_out), 32'd0);
        chks("mismatch_ready", 32'(ready_out), 32'd1);
        action_valid_in = 1'b1;
        tick();
        phv_valid_in = 1'b0; action_valid_in = 1'b0;
        tick();
        chks("mismatch_lat", 32'(phv_valid_out), 32'd0);
        tick();
        chks("mismatch_one_valid", 32'(phv_valid_out), 32'd1);
        chk ("mismatch_one_data", phv_out, tag(99));
        tick();
        chks("mismatch_only_one", 32'(phv_valid_out), 32'd0);

        // Streaming: simultaneous push/pop, order preserved
        for (int c = 0; c < 8; c++) begin
            phv_in = tag(10 + c); action_in = '0;
            phv_valid_in = (c < 6); action_valid_in = (c < 6);
            tick();
            if (c >= 2) begin
                chks("stream_valid", 32'(phv_valid_out), 32'd1);
                chk ("stream_data", phv_out, tag(10 + c - 2));
            end
        end
        phv_valid_in = 1'b0; action_valid_in = 1'b0;
        chks("stream_ready", 32'(ready_out), 32'd1);
        tick();
        chks("stream_drained", 32'(phv_valid_out), 32'd0);

        // Backpressure: exactly DEPTH accepts, stable head, in-order drain
        ready_in = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            phv_in = tag(20 + acc); action_in = '0;
            phv_valid_in = 1'b1; action_valid_in = 1'b1;
            r = ready_out;
            tick();
            if (r) acc++;
        end
        chks("bp_accepts", 32'(acc), 32'd4);
        chks("bp_ready_low", 32'(ready_out), 32'd0);
        phv_valid_in = 1'b0; action_valid_in = 1'b0;
        tick(); tick(); tick();
        chks("bp_head_valid", 32'(phv_valid_out), 32'd1);
        chk ("bp_head_stable", phv_out, tag(20));
`ifdef ACTION_ENGINE_STATS_EN
        chks("bp_stall_cnt", stat_stall_cnt, 32'd8);
        chks("bp_pkt_cnt", stat_pkt_cnt, 32'd10);
`endif
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chks("bp_drain_valid", 32'(phv_valid_out), 32'd1);
            chk ("bp_drain_data", phv_out, tag(20 + k));
            tick();
        end
        chks("bp_empty", 32'(phv_valid_out), 32'd0);

        // Reset with two PHVs in flight
        phv_in = tag(40); action_in = '0;
        phv_valid_in = 1'b1; action_valid_in = 1'b1;
        tick();
        phv_in = tag(41);
        tick();
        phv_valid_in = 1'b0; action_valid_in = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chks("rstmid_valid", 32'(phv_valid_out), 32'd0);
        chks("rstmid_ready", 32'(ready_out), 32'd1);
        chk ("rstmid_phv_out", phv_out, '0);
`ifdef ACTION_ENGINE_STATS_EN
        chks("rstmid_pkt_cnt", stat_pkt_cnt, 32'd0);
        chks("rstmid_stall_cnt", stat_stall_cnt, 32'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            tick();
            chks("rstmid_discarded", 32'(phv_valid_out), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
